mdu_iterative: RTL and testbench

//  RV32M multiply/divide unit fed by the register file read ports (rs1/rs2 data) and feeding
//  its write port (rd_addr/rd_data/rd_wren). Iterative radix-2: one result bit-step per cycle.

---
 rtl/mdu_iterative.sv | 160 ++++++++++++++++
 tb/tb_mdu_iterative.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mdu_iterative.sv
`default_nettype none
// ============================================================================
// Module   : mdu_iterative
// Brief    : RV32M multiply/divide unit, radix-2, one result bit per cycle.
// Revision : 1.0
// ============================================================================
module mdu_iterative #(
    parameter int XLEN         = 32,
    parameter bit FAST_SPECIAL = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic            kill_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [4:0]      rd_addr_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            rd_wren_o,
    output logic [4:0]      rd_addr_o,
    output logic [XLEN-1:0] rd_data_o
);
    localparam int               c_CNT_W    = $clog2(XLEN);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(XLEN - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_FIX  = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    logic [1:0]          r_state;
    logic [1:0]          w_state_next;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [2*XLEN-1:0]   r_acc;
    logic [XLEN-1:0]     r_op;
    logic [2:0]          r_funct3;
    logic                r_neg_prod;
    logic                r_neg_rem;
    logic                r_special;
    logic [XLEN-1:0]     r_spec_val;
    logic [4:0]          r_rd;

    // Operand decode at accept: MULH/MULHSU/DIV/REM sign-extend rs1, MULH/DIV/REM rs2.
    logic            w_is_div, w_a_neg, w_b_neg, w_div_zero, w_div_ovf, w_special;
    logic [XLEN-1:0] w_a_mag, w_b_mag, w_spec_val;

    assign w_is_div   = funct3_i[2];
    assign w_a_neg    = rs1_data_i[XLEN-1] & (funct3_i == 3'b001 || funct3_i == 3'b010 ||
                                              funct3_i == 3'b100 || funct3_i == 3'b110);
    assign w_b_neg    = rs2_data_i[XLEN-1] & (funct3_i == 3'b001 || funct3_i == 3'b100 ||
                                              funct3_i == 3'b110);
    assign w_a_mag    = w_a_neg ? -rs1_data_i : rs1_data_i;
    assign w_b_mag    = w_b_neg ? -rs2_data_i : rs2_data_i;
    assign w_div_zero = w_is_div & (rs2_data_i == '0);
    assign w_div_ovf  = w_is_div & ~funct3_i[0] & (rs1_data_i == {1'b1, {(XLEN-1){1'b0}}}) &
                        (rs2_data_i == '1);
    assign w_special  = w_div_zero | w_div_ovf;
    assign w_spec_val = w_div_zero ? (funct3_i[1] ? rs1_data_i : '1)
                                   : (funct3_i[1] ? '0 : rs1_data_i);

    // Iteration step: shift-add multiply / restoring divide over one shared accumulator.
    logic [XLEN:0]     w_mul_sum, w_rem_sh, w_diff;
    logic [2*XLEN-1:0] w_mul_next, w_div_next;

    assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_op} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};
    assign w_rem_sh   = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    assign w_diff     = w_rem_sh - {1'b0, r_op};
    assign w_div_next = w_diff[XLEN] ? {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                     : {w_diff[XLEN-1:0],   r_acc[XLEN-2:0], 1'b1};

    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quot, w_rem, w_fix_val, w_result;
    logic              w_accept, w_enter_done;

    assign w_prod = r_neg_prod ? -r_acc : r_acc;
    assign w_quot = r_acc[XLEN-1:0];
    assign w_rem  = r_acc[2*XLEN-1:XLEN];

    always_comb begin
        w_fix_val = '0;
        case (r_funct3)
            3'b000:  w_fix_val = w_prod[XLEN-1:0];
            3'b100:  w_fix_val = r_neg_prod ? -w_quot : w_quot;
            3'b101:  w_fix_val = w_quot;
            3'b110:  w_fix_val = r_neg_rem ? -w_rem : w_rem;
            3'b111:  w_fix_val = w_rem;
            default: w_fix_val = w_prod[2*XLEN-1:XLEN];
        endcase
        if (r_special) w_fix_val = r_spec_val;
    end

    // DONE is reached from IDLE only via the fast special path.
    assign w_result     = (r_state == c_IDLE) ? w_spec_val : w_fix_val;
    assign w_accept     = (r_state == c_IDLE) & start_i & ~kill_i;
    assign w_enter_done = (r_state != c_DONE) & (w_state_next == c_DONE);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) r_state <= c_IDLE;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (kill_i && r_state != c_IDLE) begin
            w_state_next = c_IDLE;
        end else begin
            case (r_state)
                c_IDLE: if (w_accept) w_state_next = (FAST_SPECIAL && w_special) ? c_DONE : c_CALC;
                c_CALC: if (r_cnt == c_CNT_LAST) w_state_next = c_FIX;
                c_FIX:  w_state_next = c_DONE;
                default: w_state_next = c_IDLE;
            endcase
        end
    end

    always_comb begin
        busy_o    = (r_state != c_IDLE);
        done_o    = (r_state == c_DONE);
        rd_wren_o = (r_state == c_DONE) && (rd_addr_o != 5'd0);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_cnt      <= '0;
            r_acc      <= '0;
            r_op       <= '0;
            r_funct3   <= 3'b000;
            r_neg_prod <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_special  <= 1'b0;
            r_spec_val <= '0;
            r_rd       <= 5'd0;
            rd_addr_o  <= 5'd0;
            rd_data_o  <= '0;
        end else begin
            if (w_accept) begin
                r_cnt      <= '0;
                r_acc      <= {{XLEN{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
                r_op       <= w_is_div ? w_b_mag : w_a_mag;
                r_funct3   <= funct3_i;
                r_neg_prod <= w_a_neg ^ w_b_neg;
                r_neg_rem  <= w_a_neg;
                r_special  <= w_special;
                r_spec_val <= w_spec_val;
                r_rd       <= rd_addr_i;
            end else if (r_state == c_CALC) begin
                r_cnt <= r_cnt + 1'b1;
                r_acc <= r_funct3[2] ? w_div_next : w_mul_next;
            end
            if (w_enter_done) begin
                rd_data_o <= w_result;
                rd_addr_o <= (r_state == c_IDLE) ? rd_addr_i : r_rd;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_mdu_iterative.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_iterative
// Brief    : Scoreboard bench for mdu_iterative against an arithmetic RV32M model.
// Revision : 1.0
// ============================================================================
module tb_mdu_iterative;
    localparam int XLEN = 32;
    localparam logic [31:0] MIN_INT = 32'h8000_0000;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic        kill_i = 1'b0;
    logic [2:0]  funct3_i = 3'b000;
    logic [31:0] rs1_data_i = '0;
    logic [31:0] rs2_data_i = '0;
    logic [4:0]  rd_addr_i = 5'd0;
    logic        busy_o, done_o, rd_wren_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;

    mdu_iterative #(.XLEN(XLEN), .FAST_SPECIAL(1'b1)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .kill_i(kill_i),
        .funct3_i(funct3_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
        .rd_addr_i(rd_addr_i), .busy_o(busy_o), .done_o(done_o), .rd_wren_o(rd_wren_o),
        .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o)
    );

    always #5 clk_i = ~clk_i;

    int unsigned cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  addr;
        logic        wren;
        int unsigned when;
    } exp_t;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // RISC-V M-extension results computed with plain signed/unsigned arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        int                ia = a;
        int                ib = b;
        longint            sa = ia;
        longint            sbv = ib;
        longint            ub = {32'b0, b};
        longint unsigned   pu = {32'b0, a} * {32'b0, b};
        logic [63:0]       p;
        case (f)
            3'b000: begin p = sa * sbv; return p[31:0]; end
            3'b001: begin p = sa * sbv; return p[63:32]; end
            3'b010: begin p = sa * ub;  return p[63:32]; end
            3'b011: return pu[63:32];
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MIN_INT && b == 32'hFFFF_FFFF) return MIN_INT;
                return ia / ib;
            end
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (a == MIN_INT && b == 32'hFFFF_FFFF) return 32'h0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] a,
                                      input logic [31:0] b);
        if (!f[2]) return 1'b0;
        if (b == 0) return 1'b1;
        return (!f[0]) && (a == MIN_INT) && (b == 32'hFFFF_FFFF);
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk_i) begin
        exp_t e;
        if (rst_ni && done_o === 1'b1) begin
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done_o=1 rd_data=0x%0h, expected no done (cycle %0d)",
                         rd_data_o, cyc);
            end else begin
                e = sb_q.pop_front();
                check("rd_data", {32'b0, rd_data_o}, {32'b0, e.data});
                check("rd_addr", {59'b0, rd_addr_o}, {59'b0, e.addr});
                check("rd_wren", {63'b0, rd_wren_o}, {63'b0, e.wren});
                check("latency", {32'b0, cyc}, {32'b0, e.when});
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy_o && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 100) check("idle_timeout", {63'b0, busy_o}, 64'd0);
    endtask

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        exp_t e;
        @(negedge clk_i);
        funct3_i = f; rs1_data_i = a; rs2_data_i = b; rd_addr_i = rd; start_i = 1'b1;
        e.data = ref_model(f, a, b);
        e.addr = rd;
        e.wren = (rd != 5'd0);
        e.when = cyc + (is_special(f, a, b) ? 1 : XLEN + 2);
        sb_q.push_back(e);
        @(negedge clk_i);
        start_i = 1'b0;
        rs1_data_i = $urandom; rs2_data_i = $urandom; rd_addr_i = 5'($urandom);
        wait_idle();
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return MIN_INT;
            3: return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int unsigned t0;
        repeat (2) @(negedge clk_i);
        check("reset_busy", {63'b0, busy_o}, 64'd0);
        check("reset_done", {63'b0, done_o}, 64'd0);
        check("reset_data", {32'b0, rd_data_o}, 64'd0);
        rst_ni = 1'b1;

        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5);
        issue(3'b000, 32'hFFFF_FFF9, 32'd3, 5'd1);
        issue(3'b001, 32'hFFFF_FFF9, 32'd3, 5'd2);
        issue(3'b010, 32'hFFFF_FFFF, 32'd2, 5'd3);
        issue(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd4);
        issue(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6);
        issue(3'b101, 32'd100, 32'd7, 5'd7);
        issue(3'b111, 32'd100, 32'd7, 5'd8);
        issue(3'b100, 32'd5, 32'd0, 5'd9);
        issue(3'b110, 32'd5, 32'd0, 5'd10);
        issue(3'b100, MIN_INT, 32'hFFFF_FFFF, 5'd11);
        issue(3'b110, MIN_INT, 32'hFFFF_FFFF, 5'd12);
        issue(3'b101, MIN_INT, 32'hFFFF_FFFF, 5'd13);
        issue(3'b000, 32'h1234_5678, 32'h9ABC_DEF0, 5'd0);

        // Second start while busy is dropped; kill abandons the op without a done pulse.
        @(negedge clk_i);
        funct3_i = 3'b000; rs1_data_i = 32'd3; rs2_data_i = 32'd4; rd_addr_i = 5'd14;
        start_i = 1'b1;
        t0 = cyc;
        @(negedge clk_i); start_i = 1'b0;
        while (cyc < t0 + 5) @(negedge clk_i);
        start_i = 1'b1; rd_addr_i = 5'd15;
        @(negedge clk_i); start_i = 1'b0;
        while (cyc < t0 + 10) @(negedge clk_i);
        kill_i = 1'b1;
        @(negedge clk_i); kill_i = 1'b0;
        check("kill_to_idle", {63'b0, busy_o}, 64'd0);
        repeat (40) @(negedge clk_i);
        check("kill_no_requeue", {63'b0, busy_o}, 64'd0);

        // Kill and start together in IDLE: request is dropped.
        start_i = 1'b1; kill_i = 1'b1;
        @(negedge clk_i); start_i = 1'b0; kill_i = 1'b0;
        check("kill_idle_drop", {63'b0, busy_o}, 64'd0);

        // Reset in the middle of a divide.
        @(negedge clk_i);
        funct3_i = 3'b100; rs1_data_i = 32'd1000; rs2_data_i = 32'd3; rd_addr_i = 5'd16;
        start_i = 1'b1;
        t0 = cyc;
        @(negedge clk_i); start_i = 1'b0;
        while (cyc < t0 + 20) @(negedge clk_i);
        rst_ni = 1'b0;
        @(negedge clk_i);
        check("rst_busy", {63'b0, busy_o}, 64'd0);
        check("rst_done", {63'b0, done_o}, 64'd0);
        check("rst_wren", {63'b0, rd_wren_o}, 64'd0);
        check("rst_addr", {59'b0, rd_addr_o}, 64'd0);
        check("rst_data", {32'b0, rd_data_o}, 64'd0);
        rst_ni = 1'b1;
        repeat (40) @(negedge clk_i);

        issue(3'b101, 32'd77, 32'd5, 5'd0);

        for (int i = 0; i < 40; i++) begin
            issue(3'($urandom_range(0, 7)), pick(), pick(), 5'($urandom_range(0, 31)));
        end

        repeat (5) @(negedge clk_i);
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
